// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory: core (c_*) vs loader (l_*).
// Round-robin grant in IDLE, fixed-latency read sequencing in BUSY, core stall generation.
module dmem_arbiter #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int MEM_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  c_req,
  input  logic                  c_we,
  input  logic [ADDR_WIDTH-1:0] c_addr,
  input  logic [DATA_WIDTH-1:0] c_wdata,
  output logic                  c_gnt,
  output logic                  c_rvalid,
  output logic [DATA_WIDTH-1:0] c_rdata,
  input  logic                  l_req,
  input  logic                  l_we,
  input  logic [ADDR_WIDTH-1:0] l_addr,
  input  logic [DATA_WIDTH-1:0] l_wdata,
  output logic                  l_gnt,
  output logic                  l_rvalid,
  output logic [DATA_WIDTH-1:0] l_rdata,
  output logic                  stall,
  output logic                  m_en,
  output logic                  m_we,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [DATA_WIDTH-1:0] m_wdata,
  input  logic [DATA_WIDTH-1:0] m_rdata
);

  localparam int CW = $clog2(MEM_LATENCY + 1);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  // owner/last: 1 = loader, 0 = core
  logic          r_owner, w_owner_nxt;
  logic          r_last, w_last_nxt;
  logic          w_win_c, w_win_l, w_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_owner <= w_owner_nxt;
      r_last  <= w_last_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last;
    w_win_c     = 1'b0;
    w_win_l     = 1'b0;
    w_done      = 1'b0;
    m_en        = 1'b0;
    m_we        = 1'b0;
    m_addr      = '0;
    m_wdata     = '0;
    if (!reset) begin
      unique case (r_state)
        S_IDLE: begin
          w_win_c = c_req & (~l_req | r_last);
          w_win_l = l_req & (~c_req | ~r_last);
          if (w_win_c) begin
            m_en    = 1'b1;
            m_we    = c_we;
            m_addr  = c_addr;
            m_wdata = c_wdata;
          end else if (w_win_l) begin
            m_en    = 1'b1;
            m_we    = l_we;
            m_addr  = l_addr;
            m_wdata = l_wdata;
          end
          if (m_en) w_last_nxt = w_win_l;
          if (m_en && !m_we) begin
            w_state_nxt = S_BUSY;
            w_owner_nxt = w_win_l;
            w_cnt_nxt   = CW'(MEM_LATENCY);
          end
        end
        S_BUSY: begin
          w_cnt_nxt = r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            w_done      = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign c_gnt    = w_win_c;
  assign l_gnt    = w_win_l;
  assign c_rvalid = w_done & ~r_owner;
  assign l_rvalid = w_done & r_owner;
  assign c_rdata  = c_rvalid ? m_rdata : '0;
  assign l_rdata  = l_rvalid ? m_rdata : '0;
  assign stall    = ~reset & c_req & ~(c_gnt & c_we) & ~c_rvalid;

endmodule
